mc_core_param: RTL and testbench

- Parametrised multicycle MIPS-subset core: one shared ALU, one unified instruction/data memory port, and a built-in control FSM.
- Successor to the fixed-width multicycle datapath. Adds a configurable register-file depth, a configurable reset PC, a halt state, and a req/ack memory handshake so memory latency may vary.
- Sits between the testbench and a combined instruction/data memory model.

---
 rtl/mc_core_param.sv | 222 ++++++++++++++++++++++
 tb/tb_mc_core_param.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_param.sv
// mc_core_param: parametrised multicycle MIPS-subset core with one shared ALU,
// a unified req/ack memory port and a halt state for illegal instructions.
module mc_core_param #(
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           pcQ,
    output logic [31:0]           instr,
    output logic [3:0]            state,
    output logic                  halted
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_t;

    state_t        st, st_nx;
    logic [31:0]   a, b, alu_out, mdr;
    logic [31:0]   rf [NUM_REGS];
    logic [5:0]    op, fn;
    logic [RW-1:0] rs, rt, rd;
    logic [31:0]   simm, rd_a, rd_b;
    logic          is_rt, is_r_alu, is_jr, is_addi;
    logic          is_lw, is_sw, is_beq, is_j, is_jal;
    logic [31:0]   alu_a, alu_b, alu_y;
    alu_t          alu_ctl;
    logic          rf_we;
    logic [RW-1:0] rf_wa;
    logic [31:0]   rf_wd;
    logic [31:0]   addr_full;

    assign op   = instr[31:26];
    assign fn   = instr[5:0];
    assign rs   = instr[21 +: RW];
    assign rt   = instr[16 +: RW];
    assign rd   = instr[11 +: RW];
    assign simm = {{16{instr[15]}}, instr[15:0]};
    assign rd_a = (rs == '0) ? '0 : rf[rs];
    assign rd_b = (rt == '0) ? '0 : rf[rt];

    assign is_rt    = (op == 6'b000000);
    assign is_r_alu = is_rt && (fn inside {6'b100000, 6'b100010,
                      6'b100100, 6'b100101, 6'b101010});
    assign is_jr    = is_rt && (fn == 6'b001000);
    assign is_addi  = (op == 6'b001000);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);

    // The single ALU also produces pcQ+4 in FETCH and the branch target in DECODE.
    always_comb begin
        alu_a   = pcQ;
        alu_b   = 32'd4;
        alu_ctl = ALU_ADD;
        unique case (st)
            S_DECODE: alu_b = {simm[29:0], 2'b00};
            S_MEMADR, S_ADDIEX: begin
                alu_a = a;
                alu_b = simm;
            end
            S_EXEC: begin
                alu_a = a;
                alu_b = b;
                unique case (fn)
                    6'b100010: alu_ctl = ALU_SUB;
                    6'b100100: alu_ctl = ALU_AND;
                    6'b100101: alu_ctl = ALU_OR;
                    6'b101010: alu_ctl = ALU_SLT;
                    default:   alu_ctl = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = alu_a + alu_b;
        unique case (alu_ctl)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: ;
        endcase
    end

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rt;
        rf_wd = alu_out;
        unique case (st)
            S_MEMWB: begin
                rf_we = 1'b1;
                rf_wd = mdr;
            end
            S_ALUWB: begin
                rf_we = 1'b1;
                rf_wa = rd;
            end
            S_ADDIWB: rf_we = 1'b1;
            S_JUMP: begin
                rf_we = is_jal;
                rf_wa = RW'(NUM_REGS - 1);
                rf_wd = pcQ;
            end
            default: ;
        endcase
    end

    always_comb begin
        st_nx     = st;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_full = pcQ;
        unique case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) st_nx = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_lw, is_sw:  st_nx = S_MEMADR;
                    is_r_alu:      st_nx = S_EXEC;
                    is_jr:         st_nx = S_FETCH;
                    is_addi:       st_nx = S_ADDIEX;
                    is_beq:        st_nx = S_BRANCH;
                    is_j, is_jal:  st_nx = S_JUMP;
                    default:       st_nx = S_HALT;
                endcase
            end
            S_MEMADR: st_nx = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                mem_req   = 1'b1;
                addr_full = alu_out;
                if (mem_ack) st_nx = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                addr_full = alu_out;
                if (mem_ack) st_nx = S_FETCH;
            end
            S_EXEC:   st_nx = S_ALUWB;
            S_ADDIEX: st_nx = S_ADDIWB;
            S_HALT:   st_nx = S_HALT;
            default:  st_nx = S_FETCH;
        endcase
        // Requests are masked while reset is held so nothing is issued mid-reset.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    assign mem_addr  = addr_full[ADDR_WIDTH-1:0];
    assign mem_wdata = b;
    assign state     = st;
    assign halted    = (st == S_HALT);

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= S_FETCH;
            pcQ     <= RESET_PC;
            instr   <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            st <= st_nx;
            unique case (st)
                S_FETCH: begin
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        pcQ   <= alu_y;
                    end
                end
                S_DECODE: begin
                    a       <= rd_a;
                    b       <= rd_b;
                    alu_out <= alu_y;
                    if (is_jr) pcQ <= rd_a;
                end
                S_MEMADR, S_EXEC, S_ADDIEX: alu_out <= alu_y;
                S_MEMRD: if (mem_ack) mdr <= mem_rdata;
                S_BRANCH: if (a == b) pcQ <= alu_out;
                S_JUMP: pcQ <= {pcQ[31:28], instr[25:0], 2'b00};
                default: ;
            endcase
            if (rf_we && rf_wa != '0) rf[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_mc_core_param.sv
// Scoreboard bench for mc_core_param: directed programs against a
// req/ack memory model; stores are checked by a separate monitor.
module tb_mc_core_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pcq, instr;
    logic        mem_we, mem_req, mem_ack, halted;
    logic [3:0]  state;

    logic [31:0] mem [0:255];
    int          delay = 0;
    bit          spur = 1'b0;
    bit          hold_wr = 1'b0;
    int          wcnt = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;

    mc_core_param dut (
        .clock     (clock),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pcQ       (pcq),
        .instr     (instr),
        .state     (state),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ack   = spur |
        (mem_req && !(mem_we && hold_wr) && wcnt == delay);

    always @(posedge clock) begin
        cyc  <= reset ? 1 : cyc + 1;
        wcnt <= (!mem_req || mem_ack) ? 0 : wcnt + 1;
    end

    always @(negedge clock) begin
        if (!reset && mem_req && mem_we && mem_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL wr_extra: addr=%h data=%h cyc=%0d, none expected",
                         mem_addr, mem_wdata, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data ||
                    (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
                    bad++;
                    $display("FAIL wr: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             mem_addr, mem_wdata, cyc,
                             mon_e.addr, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[9:2]] = w;
    endtask

    task automatic expw(input logic [31:0] addr, input logic [31:0] d,
                        input int c);
        wr_t e;
        e.addr = addr;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic apply_reset;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_state", {28'b0, state}, 32'd0);
        chk("rst_pc", pcq, 32'h0);
        chk("rst_halt", {31'b0, halted}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic wait_halt(input int limit);
        int k = 0;
        while (!halted && k < limit) begin
            @(negedge clock);
            k++;
        end
        chk("halt_reach", {31'b0, halted}, 32'd1);
    endtask

    task automatic prog_a;
        put(32'h00, 32'h20010005);
        put(32'h04, 32'h20020007);
        put(32'h08, 32'h00221820);
        put(32'h0C, 32'hAC030040);
        put(32'h10, 32'hFFFFFFFF);
    endtask

    task automatic prog_b;
        put(32'h000, 32'h20010003);
        put(32'h004, 32'h20020003);
        put(32'h008, 32'h0C000040);
        put(32'h00C, 32'hAC070080);
        put(32'h010, 32'hFFFFFFFF);
        put(32'h100, 32'h10220002);
        put(32'h104, 32'hAC010084);
        put(32'h108, 32'hAC010088);
        put(32'h10C, 32'h20020004);
        put(32'h110, 32'h10220002);
        put(32'h114, 32'h00E00008);
    endtask

    task automatic prog_d;
        put(32'h00, 32'h2001FFFD);
        put(32'h04, 32'h20020005);
        put(32'h08, 32'h00221822);
        put(32'h0C, 32'h0022202A);
        put(32'h10, 32'h00222824);
        put(32'h14, 32'h00223025);
        put(32'h18, 32'hAC030080);
        put(32'h1C, 32'hAC040084);
        put(32'h20, 32'hAC050088);
        put(32'h24, 32'hAC06008C);
        put(32'h28, 32'h8C47008B);
        put(32'h2C, 32'hAC070094);
        put(32'h30, 32'h00220020);
        put(32'h34, 32'hAC000098);
        put(32'h38, 32'h0041182A);
        put(32'h3C, 32'hAC03009C);
        put(32'h40, 32'h20090011);
        put(32'h44, 32'hAC0100A0);
        put(32'h48, 32'h0000003F);
        put(32'h90, 32'hDEADBEEF);
    endtask

    initial begin
        // zero-wait, ack held high permanently
        clear_mem();
        prog_a();
        spur = 1'b1;
        expw(32'h40, 32'd12, 16);
        apply_reset();
        wait_cyc(17);
        chk("a_pc", pcq, 32'h10);
        wait_cyc(19);
        for (int i = 0; i < 20; i++) begin
            chk("a_halt_hold", {26'b0, halted, mem_req, state},
                {26'b0, 6'b101100});
            @(negedge clock);
        end
        chk("a_drain", exp_q.size(), 0);

        // three wait cycles on every request
        @(posedge clock);
        #1 spur = 1'b0;
        delay = 3;
        expw(32'h40, 32'd12, 31);
        apply_reset();
        wait_cyc(3);
        chk("w_fetch_hold", {27'b0, mem_req, state}, 32'h10);
        chk("w_fetch_addr", mem_addr, 32'h0);
        chk("w_fetch_ir", instr, 32'h0);
        wait_cyc(5);
        chk("w_decode", {28'b0, state}, 32'd1);
        chk("w_ir", instr, 32'h20010005);
        wait_cyc(28);
        chk("w_wr_start", {26'b0, mem_req, mem_we, state}, 32'h35);
        chk("w_wr_addr", mem_addr, 32'h40);
        wait_cyc(30);
        chk("w_wr_stable", mem_addr ^ mem_wdata, 32'h40 ^ 32'd12);
        wait_cyc(32);
        chk("w_pc", pcq, 32'h10);
        wait_halt(40);
        chk("w_drain", exp_q.size(), 0);

        // branches, jal and jr
        @(posedge clock);
        #1 delay = 0;
        clear_mem();
        prog_b();
        expw(32'h80, 32'hC, 27);
        apply_reset();
        wait_cyc(12);
        chk("b_jal_pc", pcq, 32'h100);
        wait_cyc(15);
        chk("b_beq_taken", pcq, 32'h10C);
        chk("b_beq_t_st", {28'b0, state}, 32'd0);
        wait_cyc(22);
        chk("b_beq_not", pcq, 32'h114);
        chk("b_beq_n_st", {28'b0, state}, 32'd0);
        wait_cyc(24);
        chk("b_jr_pc", pcq, 32'hC);
        wait_halt(40);
        chk("b_drain", exp_q.size(), 0);

        // ALU ops, lw, reg 0, field truncation, illegal funct
        @(posedge clock);
        #1 clear_mem();
        prog_d();
        expw(32'h80, 32'hFFFFFFF8, -1);
        expw(32'h84, 32'h1, -1);
        expw(32'h88, 32'h5, -1);
        expw(32'h8C, 32'hFFFFFFFD, -1);
        expw(32'h94, 32'hDEADBEEF, -1);
        expw(32'h98, 32'h0, -1);
        expw(32'h9C, 32'h0, -1);
        expw(32'hA0, 32'h11, -1);
        apply_reset();
        wait_halt(400);
        chk("d_ir", instr, 32'h0000003F);
        chk("d_drain", exp_q.size(), 0);

        // reset while a store is stalled
        @(posedge clock);
        #1 clear_mem();
        prog_a();
        hold_wr = 1'b1;
        apply_reset();
        wait_cyc(20);
        chk("r_stall", {26'b0, mem_req, mem_we, state}, 32'h35);
        chk("r_addr", mem_addr, 32'h40);
        @(posedge clock);
        #1 reset = 1'b1;
        hold_wr = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("r_req", {31'b0, mem_req}, 32'd0);
        chk("r_state", {28'b0, state}, 32'd0);
        chk("r_pc", pcq, 32'h0);
        expw(32'h40, 32'd12, 16);
        apply_reset();
        wait_halt(40);
        chk("r_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
